// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg
//   Shared definitions for the data-memory arbiter:
//   - arb_state_t : lock FSM encoding (IDLE / OWN0 / OWN1)
//   - M0, M1      : master index constants used for grant select and pointer
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/dm_rr_pick.sv
// dm_rr_pick
//   Two-way round-robin picker. Purely combinational.
//   Ports:
//     req0, req1 : requests from master 0 / master 1
//     ptr        : master currently favoured when both request
//     win        : index of the winning master (only meaningful when valid)
//     valid      : at least one master is requesting
module dm_rr_pick
    import dm_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic win,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        // Contention goes to the favoured master; otherwise the lone requester wins.
        if (req0 && req1) begin
            win = ptr;
        end else if (req1) begin
            win = M1;
        end else begin
            win = M0;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter
//   Shares one DM_synch data memory (synchronous write, combinational read)
//   between master 0 (CPU LSU) and master 1 (DMA / debug loader).
//   At most one access is granted per clock: round-robin when no master owns
//   the memory, otherwise the lock owner wins until it releases, stops
//   requesting, or hits the LOCK_MAX cap while the other master waits.
//
//   Handshake: mN_req is held until mN_gnt is seen high in the same cycle;
//   the access completes at the rising edge that ends the grant cycle.
//   Reads return mN_rdata with a one-cycle mN_rvalid pulse in the cycle after
//   the grant; writes produce no response.
//
//   Ports:
//     clk, reset                 : clock, synchronous active-high reset
//     mN_req/we/addr/wdata/lock  : master N request side
//     mN_gnt                     : master N accepted this cycle (combinational)
//     mN_rdata, mN_rvalid        : master N read return (registered)
//     dm_a, dm_wd, dm_we, dm_rd  : DM_synch interface
//     dbg_state                  : current lock FSM state
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_lock,
    output logic          m0_gnt,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rvalid,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rvalid,

    output logic [AW-1:0] dm_a,
    output logic [DW-1:0] dm_wd,
    output logic          dm_we,
    input  logic [DW-1:0] dm_rd,

    output logic [1:0]    dbg_state
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_t    state;
    logic          ptr;       // master favoured on contention
    logic          sel_q;     // last-granted master; mux select when idle
    logic [CW-1:0] lock_cnt;  // consecutive grants while owning

    logic          rr_win;
    logic          rr_valid;
    logic          gnt_any;
    logic          gnt_idx;
    logic          cap_hit;
    logic          cur_we;
    logic          cur_lock;

    dm_rr_pick u_pick (
        .req0  (m0_req),
        .req1  (m1_req),
        .ptr   (ptr),
        .win   (rr_win),
        .valid (rr_valid)
    );

    // Grant decision. Reset suppresses every grant so no write can land
    // during a reset cycle.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = sel_q;
        cap_hit = (lock_cnt == CW'(LOCK_MAX));
        if (!reset) begin
            case (state)
                IDLE: begin
                    gnt_any = rr_valid;
                    if (rr_valid) gnt_idx = rr_win;
                end
                OWN0: begin
                    // At the cap a waiting m1 takes this cycle's grant.
                    if (cap_hit && m1_req) begin
                        gnt_any = 1'b1;
                        gnt_idx = M1;
                    end else if (m0_req) begin
                        gnt_any = 1'b1;
                        gnt_idx = M0;
                    end
                end
                OWN1: begin
                    if (cap_hit && m0_req) begin
                        gnt_any = 1'b1;
                        gnt_idx = M0;
                    end else if (m1_req) begin
                        gnt_any = 1'b1;
                        gnt_idx = M1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m0_gnt   = gnt_any && (gnt_idx == M0);
        m1_gnt   = gnt_any && (gnt_idx == M1);
        cur_we   = (gnt_idx == M1) ? m1_we   : m0_we;
        cur_lock = (gnt_idx == M1) ? m1_lock : m0_lock;
        dm_we    = gnt_any & cur_we;
        if (reset) begin
            dm_a  = '0;
            dm_wd = '0;
        end else begin
            dm_a  = (gnt_idx == M1) ? m1_addr  : m0_addr;
            dm_wd = (gnt_idx == M1) ? m1_wdata : m0_wdata;
        end
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= M0;
            sel_q     <= M0;
            lock_cnt  <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            // Read return: capture the combinational DM output at the end of
            // the grant cycle.
            m0_rvalid <= m0_gnt & ~m0_we;
            m1_rvalid <= m1_gnt & ~m1_we;
            if (m0_gnt && !m0_we) m0_rdata <= dm_rd;
            if (m1_gnt && !m1_we) m1_rdata <= dm_rd;

            if (gnt_any) begin
                sel_q <= gnt_idx;
                ptr   <= ~gnt_idx;
            end

            case (state)
                IDLE: begin
                    if (gnt_any && cur_lock) begin
                        state    <= (gnt_idx == M1) ? OWN1 : OWN0;
                        lock_cnt <= CW'(1);
                    end
                end
                OWN0: begin
                    if (gnt_any && gnt_idx == M1) begin
                        // Cap forced hand-over; m1 may lock in turn.
                        state    <= m1_lock ? OWN1 : IDLE;
                        lock_cnt <= m1_lock ? CW'(1) : '0;
                    end else if (!m0_req || !m0_lock) begin
                        state    <= IDLE;
                        lock_cnt <= '0;
                    end else if (!cap_hit) begin
                        lock_cnt <= lock_cnt + CW'(1);
                    end
                end
                OWN1: begin
                    if (gnt_any && gnt_idx == M0) begin
                        state    <= m0_lock ? OWN0 : IDLE;
                        lock_cnt <= m0_lock ? CW'(1) : '0;
                    end else if (!m1_req || !m1_lock) begin
                        state    <= IDLE;
                        lock_cnt <= '0;
                    end else if (!cap_hit) begin
                        lock_cnt <= lock_cnt + CW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter
//   Directed bench for dm_arbiter with a small DM_synch model
//   (64 words, word index = byte address [7:2], word i preloaded with i).
module tb_dm_arbiter;
    import dm_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          m0_req, m0_we, m0_lock;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req, m1_we, m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic [AW-1:0] dm_a;
    logic [DW-1:0] dm_wd;
    logic          dm_we;
    logic [DW-1:0] dm_rd;
    logic [1:0]    dbg_state;

    logic [DW-1:0] mem [0:63];
    logic [0:0]    exp_q[$];
    logic [0:0]    exp_w;

    int n_cmp = 0;
    int n_err = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    dm_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_lock   (m0_lock),
        .m0_gnt    (m0_gnt),
        .m0_rdata  (m0_rdata),
        .m0_rvalid (m0_rvalid),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rdata  (m1_rdata),
        .m1_rvalid (m1_rvalid),
        .dm_a      (dm_a),
        .dm_wd     (dm_wd),
        .dm_we     (dm_we),
        .dm_rd     (dm_rd),
        .dbg_state (dbg_state)
    );

    // DM_synch model
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = i;
    end
    always @(posedge clk) if (dm_we) mem[dm_a[7:2]] <= dm_wd;
    assign dm_rd = mem[dm_a[7:2]];

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();

        // reset state
        chk("rst_m0_gnt", 32'(m0_gnt), 0);
        chk("rst_m1_gnt", 32'(m1_gnt), 0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_dm_a", dm_a, 0);
        chk("rst_dm_wd", dm_wd, 0);
        chk("rst_dm_we", 32'(dm_we), 0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));

        // reset mid-op: write attempt while reset is high
        m0_req = 1; m0_we = 1; m0_addr = 8; m0_wdata = 7;
        #1;
        chk("rmid_gnt", 32'(m0_gnt), 0);
        chk("rmid_dm_we", 32'(dm_we), 0);
        tick();
        reset = 1'b0;
        clear_inputs();
        #1;
        chk("rmid_mem8", mem[2], 2);
        chk("rmid_after_m0_gnt", 32'(m0_gnt), 0);
        chk("rmid_after_m1_gnt", 32'(m1_gnt), 0);
        chk("rmid_after_m0_rvalid", 32'(m0_rvalid), 0);
        chk("rmid_after_m1_rvalid", 32'(m1_rvalid), 0);

        // single read by m0
        m0_req = 1; m0_we = 0; m0_addr = 8;
        #1;
        chk("rd_m0_gnt", 32'(m0_gnt), 1);
        chk("rd_m1_gnt", 32'(m1_gnt), 0);
        chk("rd_dm_a", dm_a, 8);
        chk("rd_dm_we", 32'(dm_we), 0);
        tick();
        m0_req = 0;
        #1;
        chk("rd_m0_rvalid", 32'(m0_rvalid), 1);
        chk("rd_m0_rdata", m0_rdata, 2);
        chk("rd_m1_rvalid", 32'(m1_rvalid), 0);
        chk("rd_m0_gnt_idle", 32'(m0_gnt), 0);
        tick();
        chk("rd_m0_rvalid_pulse", 32'(m0_rvalid), 0);
        chk("rd_m0_rdata_hold", m0_rdata, 2);

        // m1 write 42 then read back
        m1_req = 1; m1_we = 1; m1_addr = 8; m1_wdata = 42;
        #1;
        chk("wr_m1_gnt", 32'(m1_gnt), 1);
        chk("wr_dm_we", 32'(dm_we), 1);
        chk("wr_dm_wd", dm_wd, 42);
        tick();
        m1_we = 0;
        #1;
        chk("wr_no_rvalid", 32'(m1_rvalid), 0);
        chk("wr_rd_m1_gnt", 32'(m1_gnt), 1);
        chk("wr_rd_dm_we", 32'(dm_we), 0);
        tick();
        m1_req = 0;
        #1;
        chk("wr_rd_m1_rvalid", 32'(m1_rvalid), 1);
        chk("wr_rd_m1_rdata", m1_rdata, 42);
        chk("wr_rd_m0_rvalid", 32'(m0_rvalid), 0);

        // contention: alternating grants from m0
        do_reset();
        m0_req = 1; m0_addr = 4;
        m1_req = 1; m1_addr = 12;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("cont_m0_gnt", 32'(m0_gnt), 32'((i % 2) == 0));
            chk("cont_m1_gnt", 32'(m1_gnt), 32'((i % 2) == 1));
            chk("cont_not_both", 32'(m0_gnt & m1_gnt), 0);
            tick();
            if ((i % 2) == 0) begin
                chk("cont_m0_rvalid", 32'(m0_rvalid), 1);
                chk("cont_m0_rdata", m0_rdata, 1);
            end else begin
                chk("cont_m1_rvalid", 32'(m1_rvalid), 1);
                chk("cont_m1_rdata", m1_rdata, 3);
            end
        end

        // lock with starvation cap: m0 x4, m1, then m0 again
        do_reset();
        m0_req = 1; m0_lock = 1; m0_addr = 4;
        m1_req = 1; m1_addr = 12;
        exp_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_w = exp_q.pop_front();
            chk("cap_m0_gnt", 32'(m0_gnt), 32'(exp_w == M0));
            chk("cap_m1_gnt", 32'(m1_gnt), 32'(exp_w == M1));
            tick();
            if (i == 0) chk("cap_state_own0", 32'(dbg_state), 32'(OWN0));
            if (i == 4) chk("cap_state_idle", 32'(dbg_state), 32'(IDLE));
        end

        // lock release: two m0 grants, lock dropped on the second
        do_reset();
        m0_req = 1; m0_lock = 1; m0_addr = 4;
        m1_req = 1; m1_addr = 12;
        #1;
        chk("rel_c0_m0_gnt", 32'(m0_gnt), 1);
        tick();
        chk("rel_state_own0", 32'(dbg_state), 32'(OWN0));
        m0_lock = 0;
        #1;
        chk("rel_c1_m0_gnt", 32'(m0_gnt), 1);
        chk("rel_c1_m1_gnt", 32'(m1_gnt), 0);
        tick();
        chk("rel_state_idle", 32'(dbg_state), 32'(IDLE));
        #1;
        chk("rel_c2_m1_gnt", 32'(m1_gnt), 1);
        chk("rel_c2_m0_gnt", 32'(m0_gnt), 0);
        tick();

        // owner drops req: back to IDLE
        do_reset();
        m0_req = 1; m0_lock = 1; m0_addr = 4;
        #1;
        tick();
        chk("drop_state_own0", 32'(dbg_state), 32'(OWN0));
        m0_req = 0;
        tick();
        chk("drop_state_idle", 32'(dbg_state), 32'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
